// File: rtl/fully_pipelined_subtractor.sv
// Bit-serial-in-space ripple-borrow subtractor: d = a - b - bin, one full-subtractor per pipeline stage.
// Latency: WIDTH+1 enabled clk edges from input sample to d/bout/vld_out; one operation per enabled edge.
// Backpressure: none beyond en; en=0 freezes every register, so outputs hold and inputs are ignored.
// Optional build macro SIGNED_OVF_EN adds a registered signed-overflow output ovf.
module fully_pipelined_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  input  logic             vld_in,
  input  logic             en,
  output logic [WIDTH-1:0] d,
  output logic             bout,
`ifdef SIGNED_OVF_EN
  output logic             ovf,
`endif
  output logic             vld_out
);

  // Stage i holds the whole a word (bits below i already turned into
  // difference bits), only the b bits not yet consumed, the borrow coming
  // into bit i, and the valid flag travelling with the operation.
  for (genvar i = 0; i < WIDTH; i++) begin : g_stage
    localparam int BW = WIDTH - i;

    logic [WIDTH-1:0] a_q;
    logic [BW-1:0]    b_q;
    logic             br_q;
    logic             vld_q;

    logic [WIDTH-1:0] a_src;
    logic [BW-1:0]    b_src;
    logic             br_src;
    logic             vld_src;

    logic             diff;
    logic             br_nxt;
    logic [WIDTH-1:0] a_nxt;

    if (i == 0) begin : g_first
      // First stage takes the operands straight from the ports.
      assign a_src   = a;
      assign b_src   = b;
      assign br_src  = bin;
      assign vld_src = vld_in;
    end else begin : g_next
      // Later stages take the previous stage's results; b bit i-1 is dropped.
      assign a_src   = g_stage[i-1].a_nxt;
      assign b_src   = g_stage[i-1].b_q[BW:1];
      assign br_src  = g_stage[i-1].br_nxt;
      assign vld_src = g_stage[i-1].vld_q;
    end

    // Stage register: reset clears, en advances, data loads regardless of valid.
    always_ff @(posedge clk) begin
      if (rst) begin
        a_q   <= '0;
        b_q   <= '0;
        br_q  <= 1'b0;
        vld_q <= 1'b0;
      end else if (en) begin
        a_q   <= a_src;
        b_q   <= b_src;
        br_q  <= br_src;
        vld_q <= vld_src;
      end
    end

    // One full-subtractor on bit i; the difference bit overwrites a[i].
    always_comb begin
      diff     = a_q[i] ^ b_q[0] ^ br_q;
      br_nxt   = (~a_q[i] & b_q[0]) | (~(a_q[i] ^ b_q[0]) & br_q);
      a_nxt    = a_q;
      a_nxt[i] = diff;
    end
  end

  // Output register: final difference word, final borrow and valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      d       <= '0;
      bout    <= 1'b0;
      vld_out <= 1'b0;
    end else if (en) begin
      d       <= g_stage[WIDTH-1].a_nxt;
      bout    <= g_stage[WIDTH-1].br_nxt;
      vld_out <= g_stage[WIDTH-1].vld_q;
    end
  end

`ifdef SIGNED_OVF_EN
  // Signed overflow: borrow out of the MSB differs from borrow into it.
  // The MSB stage's registered borrow is the borrow into the MSB.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf <= 1'b0;
    end else if (en) begin
      ovf <= g_stage[WIDTH-1].br_nxt ^ g_stage[WIDTH-1].br_q;
    end
  end
`endif

endmodule

// File: tb/tb_fully_pipelined_subtractor.sv
// Bench for fully_pipelined_subtractor at WIDTH=4: fixed vectors, multi-cycle
// sequences (streaming, en stalls, mid-flight reset) and a randomized run
// against an arithmetic reference delay line.
module tb_fully_pipelined_subtractor;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         vld_in;
  logic         en;
  logic [W-1:0] d;
  logic         bout;
  logic         vld_out;
`ifdef SIGNED_OVF_EN
  logic         ovf;
`else
  wire          ovf = 1'b0;
`endif

  always #5 clk = ~clk;

  fully_pipelined_subtractor #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .a       (a),
    .b       (b),
    .bin     (bin),
    .vld_in  (vld_in),
    .en      (en),
    .d       (d),
    .bout    (bout),
`ifdef SIGNED_OVF_EN
    .ovf     (ovf),
`endif
    .vld_out (vld_out)
  );

  typedef struct packed {
    logic         v;
    logic [W-1:0] d;
    logic         bo;
    logic         ov;
  } res_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic [W-1:0] d;
    logic         bo;
    logic         ov;
  } vec_t;

  vec_t tbl[11];
  res_t pipe[W+1];  // pipe[0] newest operation, pipe[W] is what the outputs show
  int   n_vec = 0;
  int   n_err = 0;

  // Reference result from plain integer arithmetic.
  function automatic res_t ref_op(logic [W-1:0] ra, logic [W-1:0] rb, logic rbin, logic rv);
    res_t r;
    int   ua, ub, diff, sa, sb, sd;
    ua   = int'(ra);
    ub   = int'(rb);
    diff = ua - ub - int'(rbin);
    r.v  = rv;
    r.d  = diff[W-1:0];
    r.bo = (ua < ub + int'(rbin));
    sa   = ra[W-1] ? ua - (1 << W) : ua;
    sb   = rb[W-1] ? ub - (1 << W) : ub;
    sd   = sa - sb - int'(rbin);
`ifdef SIGNED_OVF_EN
    r.ov = (sd < -(1 << (W-1))) || (sd > (1 << (W-1)) - 1);
`else
    r.ov = 1'b0;
`endif
    return r;
  endfunction

  function automatic res_t dut_res();
    res_t r;
    r.v  = vld_out;
    r.d  = d;
    r.bo = bout;
    r.ov = ovf;
    return r;
  endfunction

  task automatic cmp(string nm, res_t exp);
    res_t act;
    act = dut_res();
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got vld=%0b d=%0d bout=%0b ovf=%0b, want vld=%0b d=%0d bout=%0b ovf=%0b",
               nm, $time, act.v, act.d, act.bo, act.ov, exp.v, exp.d, exp.bo, exp.ov);
    end
  endtask

  task automatic drive(logic [W-1:0] da, logic [W-1:0] db, logic dbin, logic dv, logic de, logic dr);
    a      = da;
    b      = db;
    bin    = dbin;
    vld_in = dv;
    en     = de;
    rst    = dr;
  endtask

  // One clock: the reference delay line follows the same rst/en rules, then
  // we move to the falling edge where outputs are sampled and inputs change.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      for (int k = 0; k <= W; k++) pipe[k] = '0;
    end else if (en) begin
      for (int k = W; k > 0; k--) pipe[k] = pipe[k-1];
      pipe[0] = ref_op(a, b, bin, vld_in);
    end
    @(negedge clk);
  endtask

  function automatic res_t mk(logic v, logic [W-1:0] rd, logic rbo, logic rov);
    res_t r;
    r.v  = v;
    r.d  = rd;
    r.bo = rbo;
`ifdef SIGNED_OVF_EN
    r.ov = rov;
`else
    r.ov = 1'b0 & rov;
`endif
    return r;
  endfunction

  initial begin
    tbl[0]  = '{4'd9,  4'd3,  1'b0, 4'd6,  1'b0, 1'b1};
    tbl[1]  = '{4'd3,  4'd9,  1'b0, 4'd10, 1'b1, 1'b1};
    tbl[2]  = '{4'd0,  4'd0,  1'b1, 4'd15, 1'b1, 1'b0};
    tbl[3]  = '{4'd15, 4'd0,  1'b0, 4'd15, 1'b0, 1'b0};
    tbl[4]  = '{4'd5,  4'd5,  1'b0, 4'd0,  1'b0, 1'b0};
    tbl[5]  = '{4'd15, 4'd15, 1'b1, 4'd15, 1'b1, 1'b0};
    tbl[6]  = '{4'd8,  4'd1,  1'b0, 4'd7,  1'b0, 1'b1};
    tbl[7]  = '{4'd7,  4'd15, 1'b0, 4'd8,  1'b1, 1'b1};
    tbl[8]  = '{4'd5,  4'd3,  1'b0, 4'd2,  1'b0, 1'b0};
    tbl[9]  = '{4'd0,  4'd15, 1'b0, 4'd1,  1'b1, 1'b0};
    tbl[10] = '{4'd15, 4'd15, 1'b0, 4'd0,  1'b0, 1'b0};

    for (int k = 0; k <= W; k++) pipe[k] = '0;

    // Reset state.
    drive('0, '0, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    tick();
    cmp("reset", mk(1'b0, 4'd0, 1'b0, 1'b0));
    drive('0, '0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Single operations from the table, each followed by bubbles; the result
    // must appear on exactly the 5th enabled edge.
    for (int t = 0; t < 11; t++) begin
      drive(tbl[t].a, tbl[t].b, tbl[t].bin, 1'b1, 1'b1, 1'b0);
      tick();
      drive('0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
      for (int e = 2; e <= W; e++) tick();
      cmp($sformatf("latency_gap_%0d", t), mk(1'b0, 4'd0, 1'b0, 1'b0));
      tick();
      cmp($sformatf("table_%0d", t), mk(1'b1, tbl[t].d, tbl[t].bo, tbl[t].ov));
    end

    // Back-to-back stream of four operations.
    drive(4'd9,  4'd3,  1'b0, 1'b1, 1'b1, 1'b0); tick();
    drive(4'd3,  4'd9,  1'b0, 1'b1, 1'b1, 1'b0); tick();
    drive(4'd5,  4'd5,  1'b0, 1'b1, 1'b1, 1'b0); tick();
    drive(4'd15, 4'd15, 1'b1, 1'b1, 1'b1, 1'b0); tick();
    cmp("stream_pre", mk(1'b0, 4'd0, 1'b0, 1'b0));
    drive('0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick(); cmp("stream_0", mk(1'b1, 4'd6,  1'b0, 1'b1));
    tick(); cmp("stream_1", mk(1'b1, 4'd10, 1'b1, 1'b1));
    tick(); cmp("stream_2", mk(1'b1, 4'd0,  1'b0, 1'b0));
    tick(); cmp("stream_3", mk(1'b1, 4'd15, 1'b1, 1'b0));
    tick(); cmp("stream_post", mk(1'b0, 4'd0, 1'b0, 1'b0));

    // Stall: en low for 3 cycles after the 2nd edge; garbage inputs ignored.
    drive(4'd9, 4'd3, 1'b0, 1'b1, 1'b1, 1'b0); tick();
    drive('0, '0, 1'b0, 1'b0, 1'b1, 1'b0);     tick();
    for (int s = 0; s < 3; s++) begin
      drive(4'($urandom), 4'($urandom), 1'($urandom), 1'b1, 1'b0, 1'b0);
      tick();
      cmp($sformatf("stall_hold_%0d", s), pipe[W]);
    end
    drive('0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick(); tick();
    cmp("stall_edge7", mk(1'b0, 4'd0, 1'b0, 1'b0));
    tick();
    cmp("stall_edge8", mk(1'b1, 4'd6, 1'b0, 1'b1));

    // Reset while three operations are in flight.
    drive(4'd9, 4'd3, 1'b0, 1'b1, 1'b1, 1'b0); tick();
    drive(4'd3, 4'd9, 1'b0, 1'b1, 1'b1, 1'b0); tick();
    drive(4'd0, 4'd0, 1'b1, 1'b1, 1'b1, 1'b1); tick();
    drive('0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int e = 0; e <= W; e++) begin
      tick();
      cmp($sformatf("flush_%0d", e), mk(1'b0, 4'd0, 1'b0, 1'b0));
    end
    drive(4'd5, 4'd3, 1'b0, 1'b1, 1'b1, 1'b0); tick();
    drive('0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int e = 2; e <= W + 1; e++) tick();
    cmp("after_reset_op", mk(1'b1, 4'd2, 1'b0, 1'b0));

    // Randomized traffic with random stalls and occasional resets.
    for (int c = 0; c < 600; c++) begin
      drive(4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom),
            ($urandom_range(0, 3) != 0), ($urandom_range(0, 39) == 0));
      tick();
      cmp("random", pipe[W]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
